// File: rtl/array_deserializer_pkg.sv
// Shared definitions for the SAP-3 register-file debug stream. The serializer and the
// deserializer both import this, so frame length and byte layout live in one place.
package sap3_dbg_pkg;

  localparam int unsigned DBG_WIDTH      = 8;
  localparam int unsigned DBG_DEPTH      = 12;
  localparam int unsigned DBG_FRAME_BITS = DBG_WIDTH * DBG_DEPTH;

  // Byte positions in the frame; 16-bit registers take two bytes, low byte first.
  localparam int unsigned IDX_B  = 0;
  localparam int unsigned IDX_C  = 1;
  localparam int unsigned IDX_D  = 2;
  localparam int unsigned IDX_E  = 3;
  localparam int unsigned IDX_H  = 4;
  localparam int unsigned IDX_L  = 5;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned IDX_Z  = 7;
  localparam int unsigned IDX_PC = 8;
  localparam int unsigned IDX_SP = 10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } dbg_rx_state_t;

endpackage

// File: rtl/array_deserializer_if.sv
// Bus between the debug stream source / monitor and the deserializer.
interface array_deserializer_if
  import sap3_dbg_pkg::*;
#(
  parameter int unsigned WIDTH = DBG_WIDTH,
  parameter int unsigned DEPTH = DBG_DEPTH
);

  localparam int unsigned FRAME_BITS = WIDTH * DEPTH;
  localparam int unsigned IDX_BITS   = $clog2(DEPTH);

  logic                  serial_in;
  logic                  start_in;
  logic [IDX_BITS-1:0]   rd_idx;
  logic [FRAME_BITS-1:0] data_flat;
  logic [WIDTH-1:0]      rd_byte;
  logic                  frame_valid;
  logic                  frame_err;
  logic [7:0]            frame_cnt;
  logic                  busy;

  // Stream source and readback side.
  modport master (
    output serial_in, start_in, rd_idx,
    input  data_flat, rd_byte, frame_valid, frame_err, frame_cnt, busy
  );

  // Deserializer side.
  modport slave (
    input  serial_in, start_in, rd_idx,
    output data_flat, rd_byte, frame_valid, frame_err, frame_cnt, busy
  );

endinterface

// File: rtl/array_deserializer.sv
// Rebuilds the 12-byte register snapshot from the serial debug stream. Bits are written
// by position into a staging word; only a complete frame is copied to data_flat.
module array_deserializer
  import sap3_dbg_pkg::*;
#(
  parameter int unsigned WIDTH = DBG_WIDTH,
  parameter int unsigned DEPTH = DBG_DEPTH
) (
  input logic                 clk,
  input logic                 rst_n,
  array_deserializer_if.slave bus
);

  localparam int unsigned FRAME_BITS = WIDTH * DEPTH;
  localparam int unsigned IDX_BITS   = $clog2(DEPTH);
  localparam logic [6:0]  LAST_BIT   = 7'(FRAME_BITS - 1);

  dbg_rx_state_t         state_q;
  logic [6:0]            bit_cnt_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] data_q;
  logic                  valid_q;
  logic                  err_q;
  logic [7:0]            cnt_q;

  // Receive FSM: position-indexed capture, frame commit, abort on early start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            shift_q[0] <= bus.serial_in;
            bit_cnt_q  <= 7'd1;
            state_q    <= RECV;
          end
        end
        RECV: begin
          if (bus.start_in) begin
            // Early restart: drop the partial frame, this bit is bit 0 of the next one.
            err_q      <= 1'b1;
            shift_q[0] <= bus.serial_in;
            bit_cnt_q  <= 7'd1;
          end else begin
            shift_q[bit_cnt_q] <= bus.serial_in;
            if (bit_cnt_q == LAST_BIT) begin
              data_q    <= {bus.serial_in, shift_q[FRAME_BITS-2:0]};
              valid_q   <= 1'b1;
              cnt_q     <= cnt_q + 8'd1;
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 7'd1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  // Byte readback mux; out-of-range indices read as zero.
  always_comb begin
    bus.rd_byte = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (bus.rd_idx == IDX_BITS'(i)) begin
        bus.rd_byte = data_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output drive from registered state.
  always_comb begin
    bus.data_flat   = data_q;
    bus.frame_valid = valid_q;
    bus.frame_err   = err_q;
    bus.frame_cnt   = cnt_q;
    bus.busy        = (state_q == RECV);
  end

endmodule

// File: tb/tb_array_deserializer.sv
// Directed bench for array_deserializer: serializer-model stimulus, hand-computed frames.
module tb_array_deserializer;
  import sap3_dbg_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   start_cyc;
  int   valid_cnt;
  int   err_cnt;
  int   both_cnt;
  int   valid_cycs[$];

  array_deserializer_if dut_if ();

  array_deserializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut_if.frame_valid) begin
        valid_cnt = valid_cnt + 1;
        valid_cycs.push_back(cyc);
      end
      if (dut_if.frame_err) err_cnt = err_cnt + 1;
      if (dut_if.frame_valid && dut_if.frame_err) both_cnt = both_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serializer model: drives bits lo..hi of frame f, start_in with bit 0.
  task automatic send_bits(input logic [95:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      dut_if.start_in  = (i == 0);
      dut_if.serial_in = f[i];
      if (i == 0) start_cyc = cyc + 1;
    end
  endtask

  task automatic idle_step();
    @(negedge clk);
    dut_if.start_in  = 1'b0;
    dut_if.serial_in = 1'b0;
    #2;
  endtask

  function automatic logic [95:0] fill(input logic [7:0] b);
    return {12{b}};
  endfunction

  logic [95:0] f_a;
  logic [95:0] f_b;
  logic [95:0] f_r;
  int          v0;
  int          e0;

  initial begin
    checks = 0; failures = 0; cyc = 0; valid_cnt = 0; err_cnt = 0; both_cnt = 0;
    rst_n = 1'b0;
    dut_if.start_in = 1'b0;
    dut_if.serial_in = 1'b0;
    dut_if.rd_idx = '0;
    for (int i = 0; i < 12; i++) f_a[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 12; i++) f_b[i*8 +: 8] = 8'(8'h50 + 8'(i * 3));

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("reset data_flat", dut_if.data_flat, 96'h0);
    chk("reset rd_byte", 96'(dut_if.rd_byte), 96'h0);
    chk("reset frame_valid", 96'(dut_if.frame_valid), 96'h0);
    chk("reset frame_err", 96'(dut_if.frame_err), 96'h0);
    chk("reset frame_cnt", 96'(dut_if.frame_cnt), 96'h0);
    chk("reset busy", 96'(dut_if.busy), 96'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame, byte i = i
    idle_step();
    send_bits(f_a, 0, 50);
    chk("single busy mid", 96'(dut_if.busy), 96'h1);
    send_bits(f_a, 51, 95);
    idle_step();
    chk("single frame_valid", 96'(dut_if.frame_valid), 96'h1);
    chk("single latency", 96'(valid_cycs[$] - start_cyc), 96'd95);
    chk("single data_flat", dut_if.data_flat, f_a);
    chk("single frame_cnt", 96'(dut_if.frame_cnt), 96'd1);
    chk("single busy after", 96'(dut_if.busy), 96'h0);
    dut_if.rd_idx = 4'd9;
    #1;
    chk("single rd_byte[9]", 96'(dut_if.rd_byte), 96'h09);
    idle_step();
    chk("single valid one cycle", 96'(dut_if.frame_valid), 96'h0);
    chk("single no err", 96'(err_cnt), 96'd0);

    // Back-to-back frames
    v0 = valid_cnt;
    send_bits(fill(8'hA5), 0, 95);
    send_bits(fill(8'h3C), 0, 95);
    idle_step();
    chk("b2b valid count", 96'(valid_cnt - v0), 96'd2);
    chk("b2b spacing", 96'(valid_cycs[$] - valid_cycs[$-1]), 96'd96);
    chk("b2b data_flat", dut_if.data_flat, fill(8'h3C));
    chk("b2b frame_cnt", 96'(dut_if.frame_cnt), 96'd3);
    chk("b2b no err", 96'(err_cnt), 96'd0);

    // Early restart at bit 40
    v0 = valid_cnt;
    send_bits(fill(8'h81), 0, 39);
    send_bits(fill(8'hFF), 0, 49);
    chk("restart err count", 96'(err_cnt), 96'd1);
    chk("restart data held", dut_if.data_flat, fill(8'h3C));
    chk("restart busy held", 96'(dut_if.busy), 96'h1);
    chk("restart cnt held", 96'(dut_if.frame_cnt), 96'd3);
    send_bits(fill(8'hFF), 50, 95);
    idle_step();
    chk("restart data new", dut_if.data_flat, fill(8'hFF));
    chk("restart frame_cnt", 96'(dut_if.frame_cnt), 96'd4);
    chk("restart valid count", 96'(valid_cnt - v0), 96'd1);

    // Out-of-range readback with data_flat all 0xFF
    dut_if.rd_idx = 4'd11;
    #1;
    chk("rd_byte idx 11", 96'(dut_if.rd_byte), 96'hFF);
    for (int i = 12; i < 16; i++) begin
      dut_if.rd_idx = 4'(i);
      #1;
      chk($sformatf("rd_byte oor %0d", i), 96'(dut_if.rd_byte), 96'h0);
    end
    dut_if.rd_idx = 4'd0;

    // Idle noise
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dut_if.start_in  = 1'b0;
      dut_if.serial_in = ~dut_if.serial_in;
    end
    idle_step();
    chk("noise data_flat", dut_if.data_flat, fill(8'hFF));
    chk("noise frame_cnt", 96'(dut_if.frame_cnt), 96'd4);
    chk("noise busy", 96'(dut_if.busy), 96'h0);
    chk("noise pulses", 96'((valid_cnt - v0) + (err_cnt - e0)), 96'd0);

    // Reset mid-frame at bit 60
    send_bits(f_b, 0, 59);
    rst_n = 1'b0;
    dut_if.start_in = 1'b0;
    #1;
    chk("midrst data_flat", dut_if.data_flat, 96'h0);
    chk("midrst frame_cnt", 96'(dut_if.frame_cnt), 96'h0);
    chk("midrst busy", 96'(dut_if.busy), 96'h0);
    chk("midrst rd_byte", 96'(dut_if.rd_byte), 96'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_step();
    send_bits(f_b, 0, 95);
    idle_step();
    chk("postrst data_flat", dut_if.data_flat, f_b);
    chk("postrst frame_cnt", 96'(dut_if.frame_cnt), 96'd1);

    // Counter wrap: 255 more frames brings the count back to 0
    v0 = valid_cnt;
    for (int n = 0; n < 255; n++) begin
      f_r = {$urandom, $urandom, $urandom};
      send_bits(f_r, 0, 95);
    end
    idle_step();
    chk("wrap frame_cnt", 96'(dut_if.frame_cnt), 96'd0);
    chk("wrap valid count", 96'(valid_cnt - v0), 96'd255);
    chk("wrap last data", dut_if.data_flat, f_r);
    chk("never valid and err together", 96'(both_cnt), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
